// File: rtl/mts_pl_sysref_gen_if.sv
// ---------------------------------------------------------------------------
// mts_pl_sysref_gen_if
//
// Bundles the configuration, control and status signals of the PL SYSREF
// generator into one interface. The controller side uses the master
// modport. The generator uses the slave modport.
//
// Signals
//   cfg_period  [CNT_W]     SYSREF period in pl_clk cycles (valid >= 2)
//   cfg_high    [CNT_W]     high time in cycles (valid 1..cfg_period-1)
//   cfg_npulse  [NPULSE_W]  pulses per burst, 0 = continuous
//   align_en                wait for align_tick before the first pulse
//   align_tick              single-cycle phase marker
//   arm                     start request, sampled every cycle
//   stop                    graceful stop request (level)
//   sysref_out              registered SYSREF output
//   busy                    generator is waiting for alignment or running
//   done                    one-cycle pulse when a run returns to idle
//   pulse_cnt   [NPULSE_W]  SYSREF rising edges since the last accepted arm
//   cfg_err                 sticky: the last arm was rejected for bad config
// ---------------------------------------------------------------------------
interface mts_pl_sysref_gen_if #(
  parameter int CNT_W    = 16,
  parameter int NPULSE_W = 8
);
  logic [CNT_W-1:0]    cfg_period;
  logic [CNT_W-1:0]    cfg_high;
  logic [NPULSE_W-1:0] cfg_npulse;
  logic                align_en;
  logic                align_tick;
  logic                arm;
  logic                stop;
  logic                sysref_out;
  logic                busy;
  logic                done;
  logic [NPULSE_W-1:0] pulse_cnt;
  logic                cfg_err;

  modport master (
    output cfg_period, cfg_high, cfg_npulse, align_en, align_tick, arm, stop,
    input  sysref_out, busy, done, pulse_cnt, cfg_err
  );

  modport slave (
    input  cfg_period, cfg_high, cfg_npulse, align_en, align_tick, arm, stop,
    output sysref_out, busy, done, pulse_cnt, cfg_err
  );
endinterface

// File: rtl/mts_pl_sysref_gen.sv
// ---------------------------------------------------------------------------
// mts_pl_sysref_gen
//
// Produces the PL-side SYSREF pulse train for multi-tile synchronization.
// The pulse train is periodic and has a programmable high time. It runs
// either continuously or as an N-pulse burst. The first pulse can
// optionally wait for an external phase tick.
//
// Ports
//   pl_clk     PL clock. All logic runs on the rising edge.
//   pl_resetn  Asynchronous, active-low reset.
//   bus        Configuration, control and status (slave side of
//              mts_pl_sysref_gen_if).
//
// Every output is registered. The first high cycle of sysref_out follows
// the edge that samples an accepted arm (or align_tick) directly. A run ends
// only on the last phase of a period, so a pulse is never truncated.
// ---------------------------------------------------------------------------
module mts_pl_sysref_gen #(
  parameter int CNT_W    = 16,
  parameter int NPULSE_W = 8
) (
  input logic                pl_clk,
  input logic                pl_resetn,
  mts_pl_sysref_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ALIGN = 2'd1,
    RUN        = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    phase, phase_d;
  logic [CNT_W-1:0]    phase_inc;
  logic                last_phase;
  logic                sysref_q, sysref_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;
  logic [NPULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic                latch_cfg;
  logic                burst_done;

  // Configuration captured at the accepted arm. It is held for the whole run.
  logic [CNT_W-1:0]    period_l;
  logic [CNT_W-1:0]    high_l;
  logic [NPULSE_W-1:0] npulse_l;

  // A configuration is usable only when both of these hold:
  //   - the period is at least 2 (any bit above bit 0 is set);
  //   - the high time lies strictly inside the period.
  function automatic logic cfg_ok(input logic [CNT_W-1:0] period,
                                  input logic [CNT_W-1:0] high);
    return (period[CNT_W-1:1] != '0) && (high != '0) && (high < period);
  endfunction

  // The pulse counter sticks at all-ones instead of wrapping.
  function automatic logic [NPULSE_W-1:0] sat_inc(input logic [NPULSE_W-1:0] v);
    return (&v) ? v : v + NPULSE_W'(1);
  endfunction

  assign phase_inc  = phase + CNT_W'(1);
  assign last_phase = (phase == period_l - CNT_W'(1));
  // pulse_cnt already includes the pulse that is ending. Comparing it with
  // npulse therefore asks whether the burst is complete.
  assign burst_done = (npulse_l != '0) && (pulse_cnt_q == npulse_l);

  always_comb begin
    state_d     = state;
    phase_d     = phase;
    sysref_d    = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q;
    pulse_cnt_d = pulse_cnt_q;
    latch_cfg   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.arm && !bus.stop) begin
          if (cfg_ok(bus.cfg_period, bus.cfg_high)) begin
            latch_cfg = 1'b1;
            cfg_err_d = 1'b0;
            phase_d   = '0;
            if (bus.align_en) begin
              state_d     = WAIT_ALIGN;
              pulse_cnt_d = '0;
            end else begin
              // Enter RUN directly at phase 0. This is the first rising edge.
              state_d     = RUN;
              sysref_d    = 1'b1;
              pulse_cnt_d = NPULSE_W'(1);
            end
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      WAIT_ALIGN: begin
        // stop takes priority over a tick in the same cycle.
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.align_tick) begin
          state_d     = RUN;
          phase_d     = '0;
          sysref_d    = 1'b1;
          pulse_cnt_d = sat_inc(pulse_cnt_q);
        end
      end

      RUN: begin
        if (last_phase) begin
          if (bus.stop || burst_done) begin
            state_d = IDLE;
            phase_d = '0;
            done_d  = 1'b1;
          end else begin
            phase_d     = '0;
            sysref_d    = 1'b1;
            pulse_cnt_d = sat_inc(pulse_cnt_q);
          end
        end else begin
          phase_d  = phase_inc;
          sysref_d = (phase_inc < high_l);
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and status registers.
  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      state       <= IDLE;
      phase       <= '0;
      sysref_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      sysref_q    <= sysref_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  // Latched configuration. It is loaded only on an accepted arm, so it needs
  // no reset.
  always_ff @(posedge pl_clk) begin
    if (latch_cfg) begin
      period_l <= bus.cfg_period;
      high_l   <= bus.cfg_high;
      npulse_l <= bus.cfg_npulse;
    end
  end

  assign bus.sysref_out = sysref_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pulse_cnt  = pulse_cnt_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_mts_pl_sysref_gen.sv
`timescale 1ns/1ps
module tb_mts_pl_sysref_gen;
  localparam int CNT_W    = 16;
  localparam int NPULSE_W = 8;
  localparam int PCNT_MAX = (1 << NPULSE_W) - 1;

  logic pl_clk    = 1'b0;
  logic pl_resetn = 1'b0;

  mts_pl_sysref_gen_if #(.CNT_W(CNT_W), .NPULSE_W(NPULSE_W)) bus ();

  mts_pl_sysref_gen #(.CNT_W(CNT_W), .NPULSE_W(NPULSE_W)) dut (
    .pl_clk   (pl_clk),
    .pl_resetn(pl_resetn),
    .bus      (bus.slave)
  );

  always #5 pl_clk = ~pl_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int case_id  = 0;
  int cur_t    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s case=%0d t=%0d observed=%0h expected=%0h", tag, case_id, cur_t, obs, exp);
    end
  endtask

  // Outputs are observed 1 ns after the rising edge. Inputs for the next
  // edge are driven at that same point.
  task automatic step();
    @(posedge pl_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.arm        = 1'b0;
    bus.stop       = 1'b0;
    bus.align_tick = 1'b0;
  endtask

  // Stop-request profile relative to the first high edge s. stop is held from
  // stop_off onwards (stop_off < 0 means never). There is also an optional
  // one-cycle glitch at offset glitch.
  function automatic bit stop_at(input int t, input int stop_off, input int glitch);
    return (stop_off >= 0 && t >= stop_off) || (t == glitch);
  endfunction

  // Reference model for one run. The waveform is derived arithmetically from
  // the offset t after the first high edge:
  //   - the run lasts k whole periods, where k is the first pulse that either
  //     completes the burst or has stop sampled on its last cycle;
  //   - sysref is high while (t mod period) < high;
  //   - pulse_cnt = pulses begun so far, saturated.
  task automatic run_case(input int period, input int high, input int npulse,
                          input bit aen, input int align_wait,
                          input int stop_off, input int glitch, input bit noise);
    int k;
    int total;
    int pc;
    case_id++;
    k = 0;
    for (int j = 1; j <= 4096 && k == 0; j++)
      if ((npulse != 0 && j == npulse) || stop_at(j * period - 1, stop_off, glitch)) k = j;
    if (k == 0) begin
      $display("FAIL model_end case=%0d observed=none required=finite run", case_id);
      $fatal(1, "run has no end");
    end
    total = k * period;

    bus.cfg_period = CNT_W'(period);
    bus.cfg_high   = CNT_W'(high);
    bus.cfg_npulse = NPULSE_W'(npulse);
    bus.align_en   = aen;
    bus.stop       = 1'b0;
    bus.arm        = 1'b1;
    step();
    bus.arm = 1'b0;
    cur_t = -1;
    chk("cfg_err_accept", bus.cfg_err, 0);

    if (aen) begin
      for (int w = 0; w < align_wait; w++) begin
        cur_t = w - align_wait;
        chk("wait_busy", bus.busy, 1);
        chk("wait_sysref", bus.sysref_out, 0);
        chk("wait_pcnt", bus.pulse_cnt, 0);
        if (noise) begin
          bus.cfg_period = CNT_W'($urandom);
          bus.cfg_high   = CNT_W'($urandom);
          bus.arm        = 1'($urandom);
        end
        bus.align_tick = (w == align_wait - 1);
        step();
        bus.align_tick = 1'b0;
        bus.arm        = 1'b0;
      end
    end

    for (int t = 0; t <= total; t++) begin
      cur_t = t;
      chk("sysref", bus.sysref_out, 32'((t < total) && ((t % period) < high)));
      chk("busy", bus.busy, 32'(t < total));
      chk("done", bus.done, 32'(t == total));
      pc = (t < total) ? (t / period + 1) : k;
      if (pc > PCNT_MAX) pc = PCNT_MAX;
      chk("pulse_cnt", bus.pulse_cnt, pc);
      bus.stop = (t < total) && stop_at(t, stop_off, glitch);
      if (noise && t < total - 1) begin
        bus.cfg_period = CNT_W'($urandom);
        bus.cfg_high   = CNT_W'($urandom);
        bus.cfg_npulse = NPULSE_W'($urandom);
        bus.align_en   = 1'($urandom);
        bus.arm        = 1'($urandom);
        bus.align_tick = 1'($urandom);
      end else begin
        bus.arm        = 1'b0;
        bus.align_tick = 1'b0;
      end
      step();
    end

    drive_idle();
    cur_t = total + 1;
    chk("post_done", bus.done, 0);
    chk("post_busy", bus.busy, 0);
    chk("post_sysref", bus.sysref_out, 0);
    chk("post_pcnt", bus.pulse_cnt, (k > PCNT_MAX) ? PCNT_MAX : k);
  endtask

  initial begin
    int period, high, npulse, aw, soff;
    bit aen;

    bus.cfg_period = '0;
    bus.cfg_high   = '0;
    bus.cfg_npulse = '0;
    bus.align_en   = 1'b0;
    drive_idle();

    // Reset state
    step();
    step();
    chk("rst_sysref", bus.sysref_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pcnt", bus.pulse_cnt, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    pl_resetn = 1'b1;
    step();

    // arm together with stop is ignored, even with a bad configuration
    case_id++;
    bus.cfg_period = 16'd5;
    bus.cfg_high   = 16'd5;
    bus.stop       = 1'b1;
    bus.arm        = 1'b1;
    step();
    drive_idle();
    chk("armstop_cfg_err", bus.cfg_err, 0);
    chk("armstop_busy", bus.busy, 0);

    // Rejected configurations
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    chk("bad_hi_eq_per_err", bus.cfg_err, 1);
    chk("bad_hi_eq_per_busy", bus.busy, 0);
    chk("bad_hi_eq_per_sysref", bus.sysref_out, 0);
    step();
    chk("bad_sticky", bus.cfg_err, 1);
    chk("bad_still_idle", bus.busy, 0);
    bus.cfg_period = 16'd1;
    bus.cfg_high   = 16'd1;
    bus.arm        = 1'b1;
    step();
    chk("bad_per1_busy", bus.busy, 0);
    bus.cfg_period = 16'd8;
    bus.cfg_high   = 16'd0;
    step();
    bus.arm = 1'b0;
    chk("bad_hi0_busy", bus.busy, 0);
    chk("bad_hi0_err", bus.cfg_err, 1);
    // A valid arm clears cfg_err (checked inside run_case)
    run_case(5, 2, 2, 1'b0, 0, -1, -1, 1'b0);

    // Test-plan waveforms
    run_case(8, 3, 2, 1'b0, 0, -1, -1, 1'b1);
    run_case(4, 1, 0, 1'b0, 0, 8, -1, 1'b0);
    run_case(6, 2, 1, 1'b1, 17, -1, -1, 1'b1);

    // stop in WAIT_ALIGN wins over a simultaneous align_tick, with no done
    case_id++;
    bus.cfg_period = 16'd6;
    bus.cfg_high   = 16'd2;
    bus.cfg_npulse = 8'd1;
    bus.align_en   = 1'b1;
    bus.arm        = 1'b1;
    step();
    bus.arm = 1'b0;
    chk("wa_busy", bus.busy, 1);
    step();
    bus.stop       = 1'b1;
    bus.align_tick = 1'b1;
    step();
    drive_idle();
    chk("wa_stop_busy", bus.busy, 0);
    chk("wa_stop_done", bus.done, 0);
    chk("wa_stop_sysref", bus.sysref_out, 0);
    bus.align_tick = 1'b1;
    step();
    bus.align_tick = 1'b0;
    chk("idle_tick_busy", bus.busy, 0);
    chk("idle_tick_sysref", bus.sysref_out, 0);

    // Cancelled stop request (one-cycle glitch), then a held stop
    run_case(5, 2, 0, 1'b0, 0, 12, 1, 1'b0);

    // Random configurations with disturbance during the run
    for (int r = 0; r < 8; r++) begin
      period = int'($urandom_range(12, 2));
      high   = int'($urandom_range(period - 1, 1));
      npulse = int'($urandom_range(4, 0));
      aen    = 1'($urandom_range(1, 0));
      aw     = int'($urandom_range(5, 1));
      if (npulse == 0) soff = int'($urandom_range(3 * period, 0));
      else if ($urandom_range(1, 0) == 1) soff = int'($urandom_range(2 * period, 0));
      else soff = -1;
      run_case(period, high, npulse, aen, aw, soff, -1, 1'b1);
    end

    // Boundaries: minimum period, maximum burst, pulse_cnt saturation
    run_case(2, 1, 255, 1'b0, 0, -1, -1, 1'b0);
    run_case(2, 1, 0, 1'b0, 0, 520, -1, 1'b0);
    run_case(7, 6, 1, 1'b1, 1, -1, -1, 1'b1);

    // Asynchronous reset in the middle of a high phase
    case_id++;
    bus.cfg_period = 16'd6;
    bus.cfg_high   = 16'd4;
    bus.cfg_npulse = 8'd3;
    bus.align_en   = 1'b0;
    bus.arm        = 1'b1;
    step();
    bus.arm = 1'b0;
    repeat (7) step();
    cur_t = 7;
    chk("pre_rst_sysref", bus.sysref_out, 1);
    chk("pre_rst_pcnt", bus.pulse_cnt, 2);
    #2 pl_resetn = 1'b0;
    #1;
    chk("async_rst_sysref", bus.sysref_out, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_pcnt", bus.pulse_cnt, 0);
    chk("async_rst_done", bus.done, 0);
    step();
    step();
    pl_resetn = 1'b1;
    repeat (10) step();
    chk("post_rst_sysref", bus.sysref_out, 0);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_pcnt", bus.pulse_cnt, 0);
    run_case(3, 1, 2, 1'b0, 0, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mts_pl_sysref_gen.md
# mts_pl_sysref_gen

Generates the PL-side SYSREF pulse train for multi-tile synchronization from the PL clock. It is the transmit counterpart of the PL SYSREF capture path: it sources a periodic, programmable-width SYSREF, either continuous or as an N-pulse burst, optionally aligned to an external phase tick. Its output drives the PL SYSREF net and loopback/debug capture.

## Interface
- CNT_W, 16, width of period/high-time counters and config fields
- NPULSE_W, 8, width of burst-count config and pulse counter
- pl_clk  in  1  PL clock; all logic on rising edge
- pl_resetn  in  1  asynchronous, active-low reset
- cfg_period  in  CNT_W  SYSREF period in pl_clk cycles; valid ≥ 2
- cfg_high  in  CNT_W  high time in cycles; valid 1..cfg_period-1
- cfg_npulse  in  NPULSE_W  pulses per burst; 0 = continuous
- align_en  in  1  1 = wait for align_tick before first pulse
- align_tick  in  1  single-cycle phase marker, synchronous to pl_clk
- arm  in  1  start request, sampled per cycle
- stop  in  1  graceful stop request, level
- sysref_out  out  1  registered SYSREF output
- busy  out  1  high in WAIT_ALIGN or RUN
- done  out  1  one-cycle pulse on RUN→IDLE
- pulse_cnt  out  NPULSE_W  rising edges of sysref_out since last accepted arm, saturating
- cfg_err  out  1  sticky: last arm rejected for bad config

## Operation
- States: IDLE, WAIT_ALIGN, RUN.
- IDLE: arm=1 and stop=0 → config check on live cfg_* inputs.
  - Invalid (period<2, high=0, high≥period): cfg_err←1, stay IDLE, config not latched.
  - Valid: latch period/high/npulse, cfg_err←0, pulse_cnt←0; go to WAIT_ALIGN if align_en, else RUN.
  - arm with stop=1 is ignored.
- WAIT_ALIGN: align_tick=1 → RUN; stop=1 → IDLE (no done). stop wins over a simultaneous align_tick.
- RUN: phase counter 0..period-1, wraps to 0.
  - sysref_out=1 while phase<high.
  - Each entry to phase 0 increments pulse_cnt, saturating at all-ones.
- End of RUN is evaluated at phase=period-1 only; pulses are never truncated.
  - Exit to IDLE with done if stop=1, or if npulse≠0 and the completed pulse count = npulse.
  - Otherwise wrap to phase 0.
- arm while busy is ignored. Latched config is immune to cfg_* changes while busy.
- Reset, asynchronous, any state: state=IDLE, phase=0, and sysref_out, busy, done, cfg_err, pulse_cnt all 0.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- arm sampled at edge t with align_en=0: RUN entered at edge t+1 with phase=0 and sysref_out=1. Latency is 1 cycle.
- With align_en=1: align_tick sampled at edge t gives sysref_out=1 from edge t+1.
- High for exactly `high` cycles, low for `period-high` cycles, repeating every `period` cycles.
- Burst of N: last phase (period-1) of pulse N is at edge s+N·period-1, where s is the first-high edge.
  - At edge s+N·period: busy=0, done=1 for one cycle, sysref_out=0.
- stop in RUN: sampled continuously, acted on at the next phase=period-1. stop must remain high until then; a deassert before then cancels the request.
- A new arm is accepted in the cycle after done at the earliest, i.e. when busy=0 as sampled.
- busy rises at the same edge that leaves IDLE.

## Test plan
- period=8, high=3, npulse=2, align_en=0, arm at edge 10 → sysref_out=1 on edges 11–13 and 19–21, 0 otherwise; done=1 and busy=0 at edge 27; pulse_cnt=2.
- period=4, high=1, npulse=0, arm at edge 5, stop raised at edge 14 and held → pulses at 6, 10, 14; exit after phase 3 at edge 17; done at edge 18; no pulse at 18; pulse_cnt=3.
- align_en=1, period=6, high=2, npulse=1, arm at edge 3, align_tick at edge 20 → busy=1 from edge 4, sysref_out=1 on edges 21–22, done at edge 27. A second align_tick during RUN has no effect.
- period=5, high=5, arm → cfg_err=1, busy=0, sysref_out=0. Then period=5, high=2, arm → cfg_err=0, normal pulses.
- npulse=3 running, pl_resetn low mid-high-phase → sysref_out, busy and pulse_cnt go to 0 immediately without waiting for a clock edge; after release, IDLE, and no output until the next arm.
- Changing cfg_period during RUN, and an arm pulse during RUN → no effect on the waveform or pulse_cnt.
